latch_bank_ctrl: RTL and testbench
==================================

# latch_bank_ctrl

Controller that shares a bank of level-sensitive D latches (q follows d while enable = 1) between several synchronous requesters. It arbitrates write requests round-robin and drives each latch enable as a clean, glitch-free pulse. The data and enable sequencing guarantees setup before the transparent window and hold after it. It sits between register-file clients and the latch array, so the clients never touch latch enables directly.

## Interface
- NREQ, 4, number of requesters (2..8)
- NLAT, 4, number of latches in the bank; AW = clog2(NLAT), minimum 1
- DW, 8, data width of each latch
- PULSE, 2, cycles the selected latch enable stays high (≥1)
- clock  in  1  system clock, rising edge active
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester write request; held until ack
- req_addr  in  NREQ*AW  packed latch index; slice i belongs to requester i
- req_data  in  NREQ*DW  packed write data; slice i belongs to requester i
- gnt  out  NREQ  one-hot; current owner for the whole transaction
- ack  out  NREQ  one-cycle completion pulse to the owner
- err  out  1  one-cycle pulse with ack when the owner's addr ≥ NLAT
- lat_en  out  NLAT  latch enables; at most one bit high
- lat_d  out  DW  shared data bus to all latch d inputs
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD.
- **IDLE:** if any req bit is set, the arbiter picks the winner w. Register gnt = 1<<w, lat_d = req_data[w], idx = req_addr[w]. Go to SETUP.
- **SETUP:** one cycle. lat_d is stable and all lat_en bits are 0. Go to OPEN.
- **OPEN:** lat_en[idx] = 1 for exactly PULSE cycles, timed by an internal counter. Go to HOLD. If idx ≥ NLAT, no enable rises and err is flagged.
- **HOLD:** one cycle. lat_en = 0 and lat_d is still held. Pulse ack[w], plus err if flagged. Clear gnt. Advance the RR pointer to w+1 mod NREQ. Go to IDLE.
- **Arbitration:** round-robin, starting from the pointer. The pointer resets to 0.
- **Sampling:** requests are sampled only in IDLE. Data and addr are captured once, at the grant.
- **Requester drops req mid-transaction:** the transaction still completes and ack still pulses.
- **Owner keeps req high after ack:** it is treated as a new request at the next IDLE and competes normally.
- **New or simultaneous requests while busy:** they wait. Fairness comes only from the RR pointer.
- **Outputs are registered:** lat_en comes straight from a flop, so it has no combinational path and cannot glitch.
- **Reset (async, any state):** state = IDLE; gnt, ack, err, lat_en, lat_d and busy all go to 0; RR pointer = 0. An interrupted latch write is lost, but the enable falls immediately.

## Timing
- Grant edge = cycle 0 (IDLE→SETUP).
- lat_en rises at cycle 1 and falls at cycle 1+PULSE.
- ack is high during cycle 1+PULSE, with lat_en already 0.
- IDLE is cycle 2+PULSE.
- Minimum request→ack latency is PULSE+2 cycles; throughput is one write per PULSE+3 cycles.
- lat_d is stable from one cycle before lat_en rises until at least one cycle after it falls.
- busy rises on the cycle-0 edge and falls on the IDLE edge.

## Structure
- **Package latch_bank_pkg:**
  - state enum (IDLE, SETUP, OPEN, HOLD);
  - parameter defaults;
  - a clog2 function.
- **Sub-module rr_arbiter (NREQ):**
  - inputs: req, ptr; output: one-hot winner;
  - purely combinational; the pointer register lives in the parent.
- The bench includes a behavioural latch model (q = d while en) for each NLAT entry, used as the checked load.

## Test plan
- **Single write:** req[0]=1, addr=2, data=8'hA5. Expect gnt[0] at cycle 0, lat_en=4'b0100 during cycles 1–2, ack[0] at cycle 3, latch2 q = A5, other latches unchanged.
- **Contention:** req = 4'b1111 held with distinct data. Expect grants in order 0,1,2,3,0, each ack spaced PULSE+3 = 5 cycles apart.
- **Pointer fairness:** after a grant to 2, assert req = 4'b0101. Expect the grant to go to 0 next, then 2.
- **Bad address:** with NLAT=3, addr=3, data=8'h3C. Expect lat_en to stay 0, ack and err together at cycle 3, and all latches unchanged.
- **Early drop:** req[1] drops at cycle 1. Expect the transaction to still complete with ack[1] at cycle 3 and the latch written.
- **Reset mid-OPEN:** assert reset_n=0 while lat_en is high. Expect lat_en, gnt, busy and lat_d to go to 0 asynchronously; after release, an idle req[3] is granted first (pointer at 0, no lower requesters).

Source files
------------

// File: rtl/latch_bank_pkg.sv
// Shared definitions for the latch bank controller: FSM encoding, parameter
// defaults and a constant-foldable ceiling-log2 helper.
package latch_bank_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned NLAT_DEF  = 4;
    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned PULSE_DEF = 2;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StSetup = 2'd1;
    localparam state_t StOpen  = 2'd2;
    localparam state_t StHold  = 2'd3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr and wraps; the
// pointer register itself belongs to the parent.
module rr_arbiter
    import latch_bank_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    localparam int unsigned PW  = (NREQ > 1) ? clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner
);

    // First active request at or after ptr (modulo NREQ) wins.
    always_comb begin
        logic        found;
        int unsigned j;
        winner = '0;
        found  = 1'b0;
        j      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (!found && req[PW'(j)]) begin
                winner[PW'(j)] = 1'b1;
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Shares a bank of transparent latches between several requesters. Each write
// runs SETUP -> OPEN (PULSE cycles) -> HOLD so lat_d is stable around the
// enable window; every output comes directly from a flop.
module latch_bank_ctrl
    import latch_bank_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned NLAT  = NLAT_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned PULSE = PULSE_DEF,
    localparam int unsigned AW   = (NLAT > 1) ? clog2(NLAT) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic               err,
    output logic [NLAT-1:0]    lat_en,
    output logic [DW-1:0]      lat_d,
    output logic               busy
);

    localparam int unsigned PW = (NREQ > 1) ? clog2(NREQ) : 1;
    localparam int unsigned CW = (PULSE > 1) ? clog2(PULSE) : 1;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic [NLAT-1:0] lat_en_q, lat_en_d;
    logic [DW-1:0]   lat_d_q, lat_d_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   own_q, own_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            bad_q, bad_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] winner;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner)
    );

    // Next-state logic for the write sequence and all registered outputs.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        err_d    = 1'b0;
        lat_en_d = lat_en_q;
        lat_d_d  = lat_d_q;
        idx_d    = idx_q;
        own_d    = own_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        bad_d    = bad_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    gnt_d = winner;
                    for (int i = 0; i < int'(NREQ); i++) begin
                        if (winner[i]) begin
                            own_d   = PW'(i);
                            lat_d_d = req_data[i*DW +: DW];
                            idx_d   = req_addr[i*AW +: AW];
                        end
                    end
                    state_d = StSetup;
                end
            end
            StSetup: begin
                // Out-of-range index decodes to no enable at all.
                for (int i = 0; i < int'(NLAT); i++) begin
                    lat_en_d[i] = (32'(idx_q) == 32'(i));
                end
                bad_d   = (32'(idx_q) >= NLAT);
                cnt_d   = CW'(PULSE - 1);
                state_d = StOpen;
            end
            StOpen: begin
                if (cnt_q == '0) begin
                    lat_en_d = '0;
                    ack_d    = gnt_q;
                    err_d    = bad_q;
                    state_d  = StHold;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StHold: begin
                gnt_d   = '0;
                ptr_d   = (own_q == PW'(NREQ - 1)) ? '0 : own_q + PW'(1);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // State registers; reset drops every enable immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            lat_en_q <= '0;
            lat_d_q  <= '0;
            idx_q    <= '0;
            own_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            bad_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            lat_en_q <= lat_en_d;
            lat_d_q  <= lat_d_d;
            idx_q    <= idx_d;
            own_q    <= own_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            bad_q    <= bad_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt    = gnt_q;
    assign ack    = ack_q;
    assign err    = err_q;
    assign lat_en = lat_en_q;
    assign lat_d  = lat_d_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Bench for latch_bank_ctrl: a 4-latch instance and a 3-latch instance (for
// the out-of-range address case), each driving behavioural latches. Expected
// acks are queued at stimulus time and checked by a monitor on the falling edge.
module tb_latch_bank_ctrl;

    typedef struct {
        logic [3:0]  owner;
        logic        err;
        logic [31:0] image;
        int          gap;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        lat_clr;

    logic [3:0]  req;
    logic [7:0]  req_addr;
    logic [31:0] req_data;
    logic [3:0]  gnt, ack;
    logic        err;
    logic [3:0]  lat_en;
    logic [7:0]  lat_d;
    logic        busy;

    logic [3:0]  b_req;
    logic [7:0]  b_req_addr;
    logic [31:0] b_req_data;
    logic [3:0]  b_gnt, b_ack;
    logic        b_err;
    logic [2:0]  b_lat_en;
    logic [7:0]  b_lat_d;
    logic        b_busy;

    logic [31:0] lq, lq_b;
    logic [31:0] img_a, img_b;
    exp_t        qa[$];
    exp_t        qb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_ack[2];

    latch_bank_ctrl #(
        .NREQ  (4),
        .NLAT  (4),
        .DW    (8),
        .PULSE (2)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .ack      (ack),
        .err      (err),
        .lat_en   (lat_en),
        .lat_d    (lat_d),
        .busy     (busy)
    );

    latch_bank_ctrl #(
        .NREQ  (4),
        .NLAT  (3),
        .DW    (8),
        .PULSE (2)
    ) dut3 (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (b_req),
        .req_addr (b_req_addr),
        .req_data (b_req_data),
        .gnt      (b_gnt),
        .ack      (b_ack),
        .err      (b_err),
        .lat_en   (b_lat_en),
        .lat_d    (b_lat_d),
        .busy     (b_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural latches: q follows d while en is high.
    always_latch begin
        if (lat_clr) begin
            lq <= '0;
        end else begin
            for (int i = 0; i < 4; i++) if (lat_en[i]) lq[i*8 +: 8] <= lat_d;
        end
    end

    always_latch begin
        if (lat_clr) begin
            lq_b <= '0;
        end else begin
            for (int i = 0; i < 3; i++) if (b_lat_en[i]) lq_b[i*8 +: 8] <= b_lat_d;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, req_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int d, input int i, input logic [1:0] a, input logic [7:0] v);
        if (d == 0) begin
            req_addr[i*2 +: 2] = a;
            req_data[i*8 +: 8] = v;
            req[i]             = 1'b1;
        end else begin
            b_req_addr[i*2 +: 2] = a;
            b_req_data[i*8 +: 8] = v;
            b_req[i]             = 1'b1;
        end
    endtask

    // Queue the ack expected for one write, with the latch image after it.
    task automatic push(input int d, input int owner, input int addr, input logic [7:0] v,
                        input logic e, input int gap);
        exp_t x;
        if (d == 0) begin
            if (!e) img_a[addr*8 +: 8] = v;
            x = '{4'(1 << owner), e, img_a, gap};
            qa.push_back(x);
        end else begin
            if (!e) img_b[addr*8 +: 8] = v;
            x = '{4'(1 << owner), e, img_b, gap};
            qb.push_back(x);
        end
    endtask

    task automatic wait_ack(input int d, input int i);
        int   n;
        logic a;
        n = 0;
        a = 1'b0;
        while (a !== 1'b1 && n < 40) begin
            tick();
            n++;
            a = (d == 0) ? ack[i] : b_ack[i];
        end
        check("ack_wait", 32'(a), 1);
    endtask

    task automatic score(input int d);
        exp_t        x;
        logic [3:0]  a, g;
        logic        e, en_any;
        logic [31:0] lat;
        int          sz;
        if (d == 0) begin
            a = ack; g = gnt; e = err; en_any = |lat_en; lat = lq; sz = qa.size();
        end else begin
            a = b_ack; g = b_gnt; e = b_err; en_any = |b_lat_en; lat = lq_b; sz = qb.size();
        end
        if (sz == 0) begin
            check("unexpected_ack", 32'(a), 0);
        end else begin
            if (d == 0) x = qa.pop_front();
            else        x = qb.pop_front();
            check("ack_owner", 32'(a), 32'(x.owner));
            check("gnt_at_ack", 32'(g), 32'(x.owner));
            check("err_at_ack", 32'(e), 32'(x.err));
            check("lat_en_low_at_ack", 32'(en_any), 0);
            check("latch_image", lat, x.image);
            if (x.gap != 0) check("ack_spacing", 32'(cyc - last_ack[d]), 32'(x.gap));
            last_ack[d] = cyc;
        end
    endtask

    // Monitor: every ack pulse is matched against the head of its queue.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (ack !== 4'b0)   score(0);
            if (b_ack !== 4'b0) score(1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] cdat [4];
        cdat = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset_n = 1'b0; lat_clr = 1'b1;
        req = '0; req_addr = '0; req_data = '0;
        b_req = '0; b_req_addr = '0; b_req_data = '0;
        img_a = '0; img_b = '0;
        last_ack[0] = 0; last_ack[1] = 0;
        repeat (3) tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_lat_en", 32'(lat_en), 0);
        check("rst_lat_d", 32'(lat_d), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1'b1; lat_clr = 1'b0;
        tick();

        // Contention: all four held, grants 0,1,2,3,0 spaced 5 cycles.
        for (int i = 0; i < 4; i++) set_req(0, i, 2'(i), cdat[i]);
        push(0, 0, 0, 8'h11, 1'b0, 0);
        push(0, 1, 1, 8'h22, 1'b0, 5);
        push(0, 2, 2, 8'h33, 1'b0, 5);
        push(0, 3, 3, 8'h44, 1'b0, 5);
        push(0, 0, 0, 8'h11, 1'b0, 5);
        wait_ack(0, 0); wait_ack(0, 1); wait_ack(0, 2); wait_ack(0, 3); wait_ack(0, 0);
        req = '0;
        tick();

        // Single write with cycle-accurate enable window.
        set_req(0, 0, 2'd2, 8'hA5);
        push(0, 0, 2, 8'hA5, 1'b0, 0);
        tick();
        check("sw_gnt_c0", 32'(gnt), 32'h1);
        check("sw_busy_c0", 32'(busy), 1);
        check("sw_en_setup", 32'(lat_en), 0);
        check("sw_lat_d_setup", 32'(lat_d), 32'hA5);
        tick();
        check("sw_en_c1", 32'(lat_en), 32'h4);
        tick();
        check("sw_en_c2", 32'(lat_en), 32'h4);
        tick();
        check("sw_ack_c3", 32'(ack), 32'h1);
        check("sw_lat_d_hold", 32'(lat_d), 32'hA5);
        req[0] = 1'b0;
        tick();
        check("sw_busy_idle", 32'(busy), 0);
        check("sw_gnt_idle", 32'(gnt), 0);

        // Pointer fairness: grant to 2, then 0101 goes to 0 then 2.
        set_req(0, 2, 2'd1, 8'hC3);
        push(0, 2, 1, 8'hC3, 1'b0, 0);
        wait_ack(0, 2);
        req[2] = 1'b0;
        tick();
        set_req(0, 0, 2'd3, 8'h96);
        set_req(0, 2, 2'd0, 8'h69);
        push(0, 0, 3, 8'h96, 1'b0, 0);
        push(0, 2, 0, 8'h69, 1'b0, 5);
        wait_ack(0, 0);
        req[0] = 1'b0;
        wait_ack(0, 2);
        req[2] = 1'b0;
        tick();

        // Early drop: req[1] released in cycle 1, write still completes.
        set_req(0, 1, 2'd2, 8'h5A);
        push(0, 1, 2, 8'h5A, 1'b0, 0);
        tick();
        check("ed_gnt_c0", 32'(gnt), 32'h2);
        tick();
        req[1] = 1'b0;
        tick();
        tick();
        check("ed_ack_c3", 32'(ack), 32'h2);
        tick();
        check("ed_busy_idle", 32'(busy), 0);

        // Out-of-range address on the 3-latch instance.
        set_req(1, 1, 2'd1, 8'hE1);
        push(1, 1, 1, 8'hE1, 1'b0, 0);
        wait_ack(1, 1);
        b_req[1] = 1'b0;
        tick();
        set_req(1, 0, 2'd3, 8'h3C);
        push(1, 0, 3, 8'h3C, 1'b1, 0);
        tick();
        check("ba_gnt_c0", 32'(b_gnt), 32'h1);
        tick();
        check("ba_en_c1", 32'(b_lat_en), 0);
        tick();
        check("ba_en_c2", 32'(b_lat_en), 0);
        tick();
        check("ba_ack_c3", 32'(b_ack), 32'h1);
        check("ba_err_c3", 32'(b_err), 1);
        b_req[0] = 1'b0;
        tick();

        // Reset while the enable is open.
        set_req(0, 2, 2'd3, 8'hEE);
        tick();
        tick();
        check("rm_en_open", 32'(lat_en), 32'h8);
        #2 reset_n = 1'b0;
        #1;
        check("rm_en_async", 32'(lat_en), 0);
        check("rm_gnt_async", 32'(gnt), 0);
        check("rm_busy_async", 32'(busy), 0);
        check("rm_lat_d_async", 32'(lat_d), 0);
        req = '0;
        tick();
        reset_n = 1'b1;
        tick();
        set_req(0, 3, 2'd3, 8'h77);
        push(0, 3, 3, 8'h77, 1'b0, 0);
        tick();
        check("rm_gnt_req3", 32'(gnt), 32'h8);
        wait_ack(0, 3);
        req[3] = 1'b0;
        tick();
        tick();

        check("qa_drained", 32'(qa.size()), 0);
        check("qb_drained", 32'(qb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
